// File: rtl/memory_stage_pkg.sv
// Shared pipeline types for the memory stage: instruction records, data-bus
// request/response, access sizes, funct3 codes and the memory FSM states.
package pipes;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [3:0] {NOP, ALU, BRANCH, LD, SD} decoded_op_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic {MEM_IDLE, MEM_WAIT} mem_state_t;

    typedef struct packed {
        decoded_op_t op;
        logic        regwrite;
    } control_t;

    typedef struct packed {
        control_t    ctl;
        logic [4:0]  dst;
        logic [63:0] pc;
        logic        valid;
        logic [31:0] raw_instr;
        logic [31:0] iresp_data;
        logic        ismem;
        logic        bubble;
        logic [63:0] result;
        logic [63:0] rd2;
    } excute_data_t;

    typedef struct packed {
        control_t    ctl;
        logic [4:0]  dst;
        logic [63:0] pc;
        logic        valid;
        logic [31:0] iresp_data;
        logic        ismem;
        logic        bubble;
        logic [63:0] addr;
        logic [63:0] result;
    } memory_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    function automatic excute_data_t ex_bubble();
        excute_data_t e;
        e        = '0;
        e.bubble = 1'b1;
        return e;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-bus bundle between the memory stage (master) and the data memory (slave).
interface memory_stage_if;
    import pipes::*;

    dbus_req_t  req;
    dbus_resp_t resp;

    modport master (output req, input resp);
    modport slave  (input req, output resp);
endinterface

// File: rtl/memory_stage_mem_align.sv
// Combinational byte-lane alignment: store data/strobe shift, load extract and
// sign/zero extension, plus a natural-alignment flag for the decoded size.
module mem_align
    import pipes::*;
(
    input  logic [2:0]  offset,
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [63:0] wdata_in,
    input  logic [63:0] rdata_in,
    output msize_t      size,
    output logic [7:0]  strobe,
    output logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        misaligned
);

    logic [7:0]  mask;
    logic [63:0] shifted;
    logic        zext;

    // NOTE: every output gets a default first, so no path leaves a latch behind.
    always_comb begin
        size       = MSIZE8;
        mask       = 8'hFF;
        rdata      = '0;
        misaligned = 1'b0;
        zext       = funct3[2];
        shifted    = rdata_in >> {offset, 3'b000};

        case (funct3)
            F3_LB, F3_LBU: begin size = MSIZE1; mask = 8'h01; end
            F3_LH, F3_LHU: begin size = MSIZE2; mask = 8'h03; end
            F3_LW, F3_LWU: begin size = MSIZE4; mask = 8'h0F; end
            default:       begin size = MSIZE8; mask = 8'hFF; end
        endcase

        case (size)
            MSIZE1: begin
                rdata      = zext ? {56'b0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
                misaligned = 1'b0;
            end
            MSIZE2: begin
                rdata      = zext ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
                misaligned = offset[0];
            end
            MSIZE4: begin
                rdata      = zext ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
                misaligned = |offset[1:0];
            end
            default: begin
                rdata      = shifted;
                misaligned = |offset;
            end
        endcase

        strobe = is_store ? (mask << offset) : 8'h00;
        wdata  = wdata_in << {offset, 3'b000};
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues loads/stores on the data bus and stalls upstream
// until data_ok. Optional MEM_MISALIGN_CHECK_EN suppresses misaligned accesses.
module memory_stage
    import pipes::*;
(
    input  logic         clk,
    input  logic         reset,
    input  excute_data_t dataE,
    output memory_data_t dataM,
    output dbus_req_t    dreq,
    input  dbus_resp_t   dresp,
    output logic         stallM,
    output logic         misalign
);

    excute_data_t q_q, q_d;
    mem_state_t   state_q, state_d;

    logic        is_mem, is_load, is_store, align_err, pending;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] wdata, ldata;
    logic        misaligned;
    logic        unused_bits;

    mem_align u_align (
        .offset     (q_q.result[2:0]),
        .funct3     (q_q.raw_instr[14:12]),
        .is_store   (is_store),
        .wdata_in   (q_q.rd2),
        .rdata_in   (dresp.data),
        .size       (size),
        .strobe     (strobe),
        .wdata      (wdata),
        .rdata      (ldata),
        .misaligned (misaligned)
    );

    assign unused_bits = ^{dresp.addr_ok, q_q.raw_instr[31:15], q_q.raw_instr[11:0], misaligned};

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q     <= ex_bubble();
            state_q <= MEM_IDLE;
        end else begin
            q_q     <= q_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        is_mem   = ~q_q.bubble & q_q.valid & q_q.ismem & (q_q.ctl.op inside {LD, SD});
        is_load  = q_q.ctl.op == LD;
        is_store = q_q.ctl.op == SD;
`ifdef MEM_MISALIGN_CHECK_EN
        align_err = is_mem & misaligned;
`else
        align_err = 1'b0;
`endif
        pending  = is_mem & ~align_err;
        stallM   = pending & ~dresp.data_ok;
        misalign = align_err;

        state_d = state_q;
        case (state_q)
            MEM_IDLE: if (pending && !dresp.data_ok) state_d = MEM_WAIT;
            MEM_WAIT: if (!pending || dresp.data_ok) state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase

        // q is the only request source, so holding it keeps dreq stable in WAIT.
        q_d = stallM ? q_q : dataE;

        dreq        = '0;
        dreq.valid  = pending;
        dreq.addr   = q_q.result;
        dreq.size   = size;
        dreq.strobe = pending ? strobe : 8'h00;
        dreq.data   = wdata;

        dataM            = '0;
        dataM.ctl        = q_q.ctl;
        dataM.dst        = q_q.dst;
        dataM.pc         = q_q.pc;
        dataM.valid      = q_q.valid;
        dataM.iresp_data = q_q.iresp_data;
        dataM.ismem      = q_q.ismem;
        dataM.bubble     = q_q.bubble;
        dataM.addr       = q_q.result;
        dataM.result     = (is_mem && is_load) ? ldata : q_q.result;
        if (stallM || align_err) begin
            dataM.bubble = 1'b1;
            dataM.valid  = 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a result scoreboard; covers latency,
// byte-lane alignment, extension, reset during WAIT and the misalign option.
module tb_memory_stage;
    import pipes::*;

    logic         clk = 1'b0;
    logic         reset;
    excute_data_t dataE;
    memory_data_t dataM;
    logic         stallM, misalign;

    memory_stage_if dbus ();

    memory_stage dut (
        .clk      (clk),
        .reset    (reset),
        .dataE    (dataE),
        .dataM    (dataM),
        .dreq     (dbus.req),
        .dresp    (dbus.resp),
        .stallM   (stallM),
        .misalign (misalign)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] result;
        logic [63:0] addr;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic excute_data_t mk(decoded_op_t op, logic [2:0] f3,
                                        logic [63:0] addr, logic [63:0] rd2);
        excute_data_t e;
        e              = '0;
        e.ctl.op       = op;
        e.ctl.regwrite = (op != SD);
        e.dst          = 5'd9;
        e.pc           = 64'h0000_0000_8000_0100;
        e.valid        = 1'b1;
        e.bubble       = 1'b0;
        e.ismem        = (op == LD) || (op == SD);
        e.raw_instr    = {17'h0, f3, 12'h003};
        e.iresp_data   = e.raw_instr;
        e.result       = addr;
        e.rd2          = rd2;
        return e;
    endfunction

    task automatic retire(input string tag);
        exp_t e;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL %s.sb: observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, ".result"}, dataM.result, e.result);
            check({tag, ".addr"},   dataM.addr,   e.addr);
        end
    endtask

    // Issue one memory op at a negedge; data_ok arrives lat cycles after the request.
    task automatic mem_op(input string tag, input decoded_op_t op, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] rd2,
                          input logic [63:0] rdata, input int lat, input msize_t esize,
                          input logic [7:0] estrb, input logic [63:0] edata,
                          input logic [63:0] eres);
        dataE = mk(op, f3, addr, rd2);
        sb.push_back('{result: eres, addr: addr});
        @(posedge clk);
        @(negedge clk);
        dataE = ex_bubble();
        for (int c = 0; c <= lat; c++) begin
            dbus.resp.data_ok = (c == lat);
            dbus.resp.data    = (c == lat) ? rdata : 64'hDEAD_BEEF_DEAD_BEEF;
            #1;
            check({tag, ".req_valid"}, dbus.req.valid, 1'b1);
            check({tag, ".req_addr"},  dbus.req.addr,  addr);
            check({tag, ".req_size"},  64'(dbus.req.size), 64'(esize));
            check({tag, ".req_strb"},  dbus.req.strobe, estrb);
            if (op == SD) check({tag, ".req_data"}, dbus.req.data, edata);
            check({tag, ".stall"},     stallM, (c < lat));
            check({tag, ".misalign"},  misalign, 1'b0);
            if (c == lat) begin
                check({tag, ".m_valid"}, dataM.valid, 1'b1);
                retire(tag);
            end else begin
                check({tag, ".m_valid"},  dataM.valid,  1'b0);
                check({tag, ".m_bubble"}, dataM.bubble, 1'b1);
            end
            @(negedge clk);
        end
        dbus.resp = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        dataE     = ex_bubble();
        dbus.resp = '0;
        #2;
        check("rst.req_valid", dbus.req.valid, 1'b0);
        check("rst.stall",     stallM,         1'b0);
        check("rst.misalign",  misalign,       1'b0);
        check("rst.m_bubble",  dataM.bubble,   1'b1);
        check("rst.m_valid",   dataM.valid,    1'b0);
        @(negedge clk);
        reset = 1'b0;

        mem_op("ld_fast", LD, F3_LD, 64'h8000_0010, 64'h0, 64'h0123_4567_89AB_CDEF, 0,
               MSIZE8, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF);
        mem_op("lb_late", LD, F3_LB, 64'h8000_0003, 64'h0, 64'h0000_0000_80FF_0000, 3,
               MSIZE1, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80);
        mem_op("lb_off2", LD, F3_LB, 64'h8000_0002, 64'h0, 64'h0000_0000_80FF_0000, 1,
               MSIZE1, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        mem_op("lbu",     LD, F3_LBU, 64'h8000_0002, 64'h0, 64'h0000_0000_80FF_0000, 0,
               MSIZE1, 8'h00, 64'h0, 64'h0000_0000_0000_00FF);
        mem_op("lhu",     LD, F3_LHU, 64'h8000_0006, 64'h0, 64'hBEEF_0000_0000_0000, 0,
               MSIZE2, 8'h00, 64'h0, 64'h0000_0000_0000_BEEF);
        mem_op("lh",      LD, F3_LH, 64'h8000_0002, 64'h0, 64'h0000_0000_8001_0000, 2,
               MSIZE2, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001);
        mem_op("lw",      LD, F3_LW, 64'h8000_0000, 64'h0, 64'hFFFF_FFFF_8000_0000, 0,
               MSIZE4, 8'h00, 64'h0, 64'hFFFF_FFFF_8000_0000);
        mem_op("lwu",     LD, F3_LWU, 64'h8000_0004, 64'h0, 64'hF000_0000_0000_0000, 1,
               MSIZE4, 8'h00, 64'h0, 64'h0000_0000_F000_0000);
        mem_op("sw",      SD, F3_SW, 64'h8000_0004, 64'h1234_5678, 64'h0, 1,
               MSIZE4, 8'hF0, 64'h1234_5678_0000_0000, 64'h8000_0004);
        mem_op("sb",      SD, F3_SB, 64'h8000_0007, 64'hAB, 64'h0, 0,
               MSIZE1, 8'h80, 64'hAB00_0000_0000_0000, 64'h8000_0007);
        mem_op("sh",      SD, F3_SH, 64'h8000_000A, 64'hCAFE, 64'h0, 0,
               MSIZE2, 8'h0C, 64'h0000_0000_CAFE_0000, 64'h8000_000A);
        mem_op("sd",      SD, F3_SD, 64'h8000_0018, 64'h1122_3344_5566_7788, 64'h0, 2,
               MSIZE8, 8'hFF, 64'h1122_3344_5566_7788, 64'h8000_0018);

        // Non-memory op passes straight through with no bus activity.
        dataE = mk(ALU, 3'b000, 64'h0000_0000_0000_002A, 64'h0);
        sb.push_back('{result: 64'h2A, addr: 64'h2A});
        @(posedge clk);
        @(negedge clk);
        dataE = ex_bubble();
        #1;
        check("alu.req_valid", dbus.req.valid,  1'b0);
        check("alu.req_strb",  dbus.req.strobe, 8'h00);
        check("alu.stall",     stallM,          1'b0);
        check("alu.m_valid",   dataM.valid,     1'b1);
        retire("alu");
        @(negedge clk);

        // Reset while waiting drops the request at once; a late data_ok is ignored.
        dataE = mk(LD, F3_LD, 64'h8000_0020, 64'h0);
        @(posedge clk);
        @(negedge clk);
        dataE = ex_bubble();
        @(negedge clk);
        #1;
        check("wrst.wait_valid", dbus.req.valid, 1'b1);
        check("wrst.wait_stall", stallM,         1'b1);
        reset = 1'b1;
        #1;
        check("wrst.req_valid", dbus.req.valid, 1'b0);
        check("wrst.stall",     stallM,         1'b0);
        check("wrst.m_valid",   dataM.valid,    1'b0);
        check("wrst.m_bubble",  dataM.bubble,   1'b1);
        check("wrst.misalign",  misalign,       1'b0);
        @(negedge clk);
        reset             = 1'b0;
        dbus.resp.data_ok = 1'b1;
        dbus.resp.data    = 64'h5555_AAAA_5555_AAAA;
        #1;
        check("wrst.late_valid", dataM.valid,    1'b0);
        check("wrst.late_req",   dbus.req.valid, 1'b0);
        @(negedge clk);
        #1;
        check("wrst.late_valid2", dataM.valid, 1'b0);
        dbus.resp = '0;
        @(negedge clk);

`ifdef MEM_MISALIGN_CHECK_EN
        dataE = mk(LD, F3_LW, 64'h8000_0002, 64'h0);
        @(posedge clk);
        @(negedge clk);
        dataE = ex_bubble();
        #1;
        check("mis.misalign",  misalign,       1'b1);
        check("mis.req_valid", dbus.req.valid, 1'b0);
        check("mis.stall",     stallM,         1'b0);
        check("mis.m_bubble",  dataM.bubble,   1'b1);
        check("mis.m_valid",   dataM.valid,    1'b0);
        @(negedge clk);
        #1;
        check("mis.clear", misalign, 1'b0);
        @(negedge clk);
`else
        mem_op("lw_off2", LD, F3_LW, 64'h8000_0002, 64'h0, 64'h0000_1234_5678_0000, 0,
               MSIZE4, 8'h00, 64'h0, 64'h0000_0000_1234_5678);
`endif

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb.drain: observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
